// File: rtl/clk_tick_monitor_pkg.sv
// Shared types and defaults for the divided-clock receive path.
// Holds the monitor FSM encoding and the stall/divider defaults.
package clk_tick_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } mon_state_t;

    localparam int unsigned DEFAULT_TIMEOUT     = 500000;
    localparam int unsigned DEFAULT_DIV_N       = 3;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    // Rise-to-rise distance of a divide-by-N toggle divider clocked by clk.
    function automatic int unsigned expected_period(input int unsigned n);
        return 2 * (n + 1);
    endfunction

endpackage

// File: rtl/clk_tick_monitor_sync_edge.sv
// Synchronizes an async level and emits registered one-cycle rise/fall pulses.
// Latency: SYNC_STAGES+1 edges from the sampling edge; no backpressure.
// rise_nxt is the combinational pre-image of rise, used to align same-edge updates.
module clk_tick_monitor_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_nxt,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   p_q;

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise_nxt = s & ~p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            p_q    <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            p_q    <= s;
            rise   <= s & ~p_q;
            fall   <= ~s & p_q;
        end
    end

endmodule

// File: rtl/clk_tick_monitor.sv
// Turns a slow divided clock into clk-domain edge enables, measures its period, flags stalls.
// Latency: ticks SYNC_STAGES+1 edges after sampling; period updates with tick_rise.
// No backpressure: outputs are free-running pulses and status levels.
module clk_tick_monitor
    import clk_tick_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             stalled
);

    localparam logic [WIDTH-1:0] TMO    = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] TMO_M1 = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic             rise_evt;
    mon_state_t       state_q;
    mon_state_t       state_d;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] period_d;
    logic             period_valid_d;
    logic             stalled_d;

    clk_tick_monitor_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (clk_in),
        .rise_nxt (rise_evt),
        .rise     (tick_rise),
        .fall     (tick_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt          <= cnt_d;
            period       <= period_d;
            period_valid <= period_valid_d;
            stalled      <= stalled_d;
        end
    end

    // rise_evt is the edge that raises tick_rise, so cnt reads 0 while the tick is high
    // and the period/valid update lands in the same cycle as the tick.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt;
        period_d       = period;
        period_valid_d = period_valid;
        stalled_d      = stalled;

        if (rise_evt) begin
            cnt_d     = '0;
            stalled_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    period_d       = cnt + ONE;
                    period_valid_d = 1'b1;
                    state_d        = ST_LOCKED;
                end
                ST_LOCKED: begin
                    period_d = cnt + ONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            if (cnt != TMO) begin
                cnt_d = cnt + ONE;
            end
            // Fires once, on the edge cnt arrives at TIMEOUT; a rise on that edge wins above.
            if (cnt == TMO_M1) begin
                stalled_d      = 1'b1;
                period_valid_d = 1'b0;
                state_d        = ST_IDLE;
            end
        end
    end

endmodule
